// File: rtl/jtdd2_sub_pkg.sv
// Shared constants and memory-map helpers for the Double Dragon 2 sub-CPU bus glue.
package jtdd2_sub_pkg;

  localparam int RAM_AW  = 10;
  localparam int RAM_DW  = 8;
  localparam int MAIN_AW = 9;

  localparam logic [1:0] ROM_LIMIT_TOP = 2'b11;
  localparam logic [5:0] SHARED_PAGE   = 6'b110000;
  localparam logic [3:0] NMIACK_PAGE   = 4'hD;
  localparam logic [3:0] IRQ_PAGE      = 4'hE;
  localparam logic [3:0] RST_STRETCH   = 4'd15;
  localparam logic [7:0] OPEN_BUS      = 8'hFF;

  typedef enum logic [2:0] {
    REGION_ROM,
    REGION_SHARED,
    REGION_NMIACK,
    REGION_IRQ,
    REGION_NONE
  } region_e;

  // Classifies a Z80 address; bus strobes are applied by the caller.
  function automatic region_e decode_region(input logic [15:0] addr);
    region_e region;
    region = REGION_NONE;
    if (addr[15:14] != ROM_LIMIT_TOP)        region = REGION_ROM;
    else if (addr[15:10] == SHARED_PAGE)     region = REGION_SHARED;
    else if (addr[15:12] == NMIACK_PAGE)     region = REGION_NMIACK;
    else if (addr[15:12] == IRQ_PAGE)        region = REGION_IRQ;
    return region;
  endfunction

endpackage

// File: rtl/jtdd2_sub_dpram.sv
// 1024x8 true dual-port RAM, one-cycle read latency on both ports.
// Port B is written last, so it wins a same-address collision.
module jtdd2_sub_dpram
  import jtdd2_sub_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RAM_AW-1:0] addr_a_i,
  input  logic [RAM_DW-1:0] data_a_i,
  input  logic              we_a_i,
  output logic [RAM_DW-1:0] q_a_o,
  input  logic [RAM_AW-1:0] addr_b_i,
  input  logic [RAM_DW-1:0] data_b_i,
  input  logic              we_b_i,
  output logic [RAM_DW-1:0] q_b_o
);

  logic [RAM_DW-1:0] mem_q [0:(1<<RAM_AW)-1];
  logic [RAM_DW-1:0] q_a_q;
  logic [RAM_DW-1:0] q_b_q;

  always_ff @(posedge clk) begin
    if (we_a_i) mem_q[addr_a_i] <= data_a_i;
    if (we_b_i) mem_q[addr_b_i] <= data_b_i;
  end

  // Output registers are reset even though the array is not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a_q <= '0;
      q_b_q <= '0;
    end else begin
      q_a_q <= mem_q[addr_a_i];
      q_b_q <= mem_q[addr_b_i];
    end
  end

  assign q_a_o = q_a_q;
  assign q_b_o = q_b_q;

endmodule

// File: rtl/jtdd2_sub_bus.sv
// Sub-CPU (Z80) bus glue: reset stretcher, NMI latch, address decode,
// read-data mux and the RAM shared with the main CPU.
module jtdd2_sub_bus
  import jtdd2_sub_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mcu_rstb,
  input  logic               cen4,
  input  logic [MAIN_AW-1:0] main_AB,
  input  logic               main_wrn,
  input  logic [7:0]         main_dout,
  input  logic               com_cs,
  output logic [7:0]         shared_dout,
  input  logic               mcu_halt,
  input  logic               mcu_nmi_set,
  output logic               mcu_ban,
  output logic               mcu_irqmain,
  output logic               cpu_rst_n,
  output logic               busrq_n,
  output logic               nmi_n,
  input  logic [15:0]        A,
  input  logic               mreq_n,
  input  logic               wr_n,
  input  logic               busak_n,
  input  logic [7:0]         cpu_dout,
  output logic [7:0]         cpu_din,
  output logic [15:0]        rom_addr,
  output logic               rom_cs,
  input  logic [7:0]         rom_data
);

  region_e     region;
  logic        shared_cs;
  logic        nmi_ack;
  logic        we_b;
  logic [7:0]  shared_q_a;

  logic [3:0]  rst_cnt_q, rst_cnt_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        nmi_q, nmi_d;
  logic        nmi_set_prev_q;
  logic        wr_prev_q;
  logic        we_a_q, we_a_d;

  assign region      = decode_region(A);
  assign rom_cs      = !mreq_n && (region == REGION_ROM);
  assign shared_cs   = !mreq_n && (region == REGION_SHARED);
  assign nmi_ack     = !mreq_n && !wr_n && (region == REGION_NMIACK);
  assign mcu_irqmain = !mreq_n && !wr_n && (region == REGION_IRQ);

  assign rom_addr  = A;
  assign busrq_n   = ~mcu_halt;
  assign mcu_ban   = busak_n;
  assign cpu_rst_n = cpu_rst_q;
  assign nmi_n     = ~nmi_q;
  assign we_b      = !main_wrn && com_cs && !mcu_ban;

  // The Z80 is held until 16 cen4 pulses have passed with both resets high.
  always_comb begin
    rst_cnt_d = rst_cnt_q;
    cpu_rst_d = cpu_rst_q;
    if (!mcu_rstb) begin
      rst_cnt_d = RST_STRETCH;
      cpu_rst_d = 1'b0;
    end else if (cen4) begin
      if (rst_cnt_q != 4'd0) rst_cnt_d = rst_cnt_q - 4'd1;
      else                   cpu_rst_d = 1'b1;
    end
  end

  // Acknowledge beats a simultaneous request edge.
  always_comb begin
    nmi_d = nmi_q;
    if (!cpu_rst_q)                         nmi_d = 1'b0;
    else if (nmi_ack)                       nmi_d = 1'b0;
    else if (mcu_nmi_set && !nmi_set_prev_q) nmi_d = 1'b1;
  end

  assign we_a_d = !wr_n && wr_prev_q && shared_cs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt_q      <= RST_STRETCH;
      cpu_rst_q      <= 1'b0;
      nmi_q          <= 1'b0;
      nmi_set_prev_q <= 1'b0;
      wr_prev_q      <= 1'b1;
      we_a_q         <= 1'b0;
    end else begin
      rst_cnt_q      <= rst_cnt_d;
      cpu_rst_q      <= cpu_rst_d;
      nmi_q          <= nmi_d;
      nmi_set_prev_q <= mcu_nmi_set;
      wr_prev_q      <= wr_n;
      we_a_q         <= we_a_d;
    end
  end

  always_comb begin
    cpu_din = OPEN_BUS;
    if (rom_cs)         cpu_din = rom_data;
    else if (shared_cs) cpu_din = shared_q_a;
  end

  jtdd2_sub_dpram u_shared (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr_a_i (A[RAM_AW-1:0]),
    .data_a_i (cpu_dout),
    .we_a_i   (we_a_q),
    .q_a_o    (shared_q_a),
    .addr_b_i ({1'b0, main_AB}),
    .data_b_i (main_dout),
    .we_b_i   (we_b),
    .q_b_o    (shared_dout)
  );

endmodule

// File: tb/tb_jtdd2_sub_bus.sv
// Self-checking bench for jtdd2_sub_bus: decode table, reset/NMI/RAM sequences
// and randomized shared-RAM traffic against an array model.
module tb_jtdd2_sub_bus;

  logic        clk = 1'b0;
  logic        rst_n, mcu_rstb, cen4;
  logic [8:0]  main_AB;
  logic        main_wrn, com_cs;
  logic [7:0]  main_dout, shared_dout;
  logic        mcu_halt, mcu_nmi_set, mcu_ban, mcu_irqmain;
  logic        cpu_rst_n, busrq_n, nmi_n;
  logic [15:0] A, rom_addr;
  logic        mreq_n, wr_n, busak_n, rom_cs;
  logic [7:0]  cpu_dout, cpu_din, rom_data;

  int checks = 0;
  int passed = 0;

  logic [7:0] model [0:1023];
  logic [8:0] pool [0:7];

  typedef struct {
    logic        mreqN;
    logic        wrN;
    logic [15:0] addr;
    logic [7:0]  romData;
    logic        expRomCs;
    logic        expIrq;
    logic [7:0]  expDin;
  } vec_t;

  vec_t vecs [0:10];

  always #5 clk = ~clk;

  jtdd2_sub_bus dut (
    .clk(clk), .rst_n(rst_n), .mcu_rstb(mcu_rstb), .cen4(cen4),
    .main_AB(main_AB), .main_wrn(main_wrn), .main_dout(main_dout),
    .com_cs(com_cs), .shared_dout(shared_dout), .mcu_halt(mcu_halt),
    .mcu_nmi_set(mcu_nmi_set), .mcu_ban(mcu_ban), .mcu_irqmain(mcu_irqmain),
    .cpu_rst_n(cpu_rst_n), .busrq_n(busrq_n), .nmi_n(nmi_n), .A(A),
    .mreq_n(mreq_n), .wr_n(wr_n), .busak_n(busak_n), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    mreq_n   = v.mreqN;
    wr_n     = v.wrN;
    A        = v.addr;
    rom_data = v.romData;
    #2;
    checkOutput("decode rom_cs", {15'd0, rom_cs}, {15'd0, v.expRomCs});
    checkOutput("decode irqmain", {15'd0, mcu_irqmain}, {15'd0, v.expIrq});
    checkOutput("decode cpu_din", {8'd0, cpu_din}, {8'd0, v.expDin});
    checkOutput("rom_addr", rom_addr, v.addr);
  endtask

  task automatic countRelease(input string name);
    int pulses;
    pulses = 0;
    while (!cpu_rst_n && pulses < 40) begin
      cen4 = 1'b1;
      tick();
      cen4 = 1'b0;
      pulses++;
      if (pulses == 15) checkOutput({name, " still held at 15"}, {15'd0, cpu_rst_n}, 16'd0);
      tick(); tick(); tick();
    end
    checkOutput({name, " cen4 pulses"}, pulses[15:0], 16'd16);
  endtask

  // Sub-CPU write: wr_n falls, commit one clk later, optionally held low longer.
  task automatic z80Write(input logic [9:0] addr, input logic [7:0] data, input int holdExtra);
    mreq_n = 1'b0; A = 16'hC000 | {6'd0, addr}; cpu_dout = data; wr_n = 1'b1;
    tick();
    wr_n = 1'b0;
    tick();
    tick();
    cpu_dout = ~data;
    for (int i = 0; i < holdExtra; i++) tick();
    wr_n = 1'b1; mreq_n = 1'b1;
    tick();
  endtask

  task automatic z80Read(input string name, input logic [9:0] addr, input logic [7:0] exp);
    mreq_n = 1'b0; wr_n = 1'b1; A = 16'hC000 | {6'd0, addr};
    tick();
    checkOutput(name, {8'd0, cpu_din}, {8'd0, exp});
    mreq_n = 1'b1;
  endtask

  task automatic mainWrite(input logic [8:0] addr, input logic [7:0] data, input logic busak);
    main_AB = addr; main_dout = data; com_cs = 1'b1; main_wrn = 1'b0; busak_n = busak;
    tick();
    com_cs = 1'b0; main_wrn = 1'b1; busak_n = 1'b1;
  endtask

  task automatic mainRead(input string name, input logic [8:0] addr, input logic [7:0] exp);
    main_AB = addr;
    tick();
    checkOutput(name, {8'd0, shared_dout}, {8'd0, exp});
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 16'h8000, 8'h37, 1'b1, 1'b0, 8'h37};
    vecs[1]  = '{1'b0, 1'b1, 16'h0000, 8'hA1, 1'b1, 1'b0, 8'hA1};
    vecs[2]  = '{1'b0, 1'b1, 16'hBFFF, 8'h4C, 1'b1, 1'b0, 8'h4C};
    vecs[3]  = '{1'b0, 1'b1, 16'hC800, 8'h12, 1'b0, 1'b0, 8'hFF};
    vecs[4]  = '{1'b0, 1'b1, 16'hC400, 8'h12, 1'b0, 1'b0, 8'hFF};
    vecs[5]  = '{1'b0, 1'b0, 16'hE000, 8'h12, 1'b0, 1'b1, 8'hFF};
    vecs[6]  = '{1'b0, 1'b1, 16'hE000, 8'h12, 1'b0, 1'b0, 8'hFF};
    vecs[7]  = '{1'b0, 1'b1, 16'hF123, 8'h12, 1'b0, 1'b0, 8'hFF};
    vecs[8]  = '{1'b1, 1'b1, 16'h8000, 8'h66, 1'b0, 1'b0, 8'hFF};
    vecs[9]  = '{1'b1, 1'b0, 16'hE000, 8'h66, 1'b0, 1'b0, 8'hFF};
    vecs[10] = '{1'b0, 1'b0, 16'hFFFF, 8'h66, 1'b0, 1'b0, 8'hFF};

    rst_n = 1'b0; mcu_rstb = 1'b1; cen4 = 1'b0;
    main_AB = '0; main_wrn = 1'b1; main_dout = '0; com_cs = 1'b0;
    mcu_halt = 1'b0; mcu_nmi_set = 1'b0;
    A = 16'hC000; mreq_n = 1'b0; wr_n = 1'b1; busak_n = 1'b1;
    cpu_dout = '0; rom_data = '0;
    tick(); tick();

    checkOutput("reset cpu_rst_n", {15'd0, cpu_rst_n}, 16'd0);
    checkOutput("reset nmi_n", {15'd0, nmi_n}, 16'd1);
    checkOutput("reset shared_dout", {8'd0, shared_dout}, 16'd0);
    checkOutput("reset port-A q", {8'd0, cpu_din}, 16'd0);
    mcu_halt = 1'b1;
    #1;
    checkOutput("busrq_n", {15'd0, busrq_n}, 16'd0);
    mcu_halt = 1'b0; mreq_n = 1'b1;

    rst_n = 1'b1;
    tick();
    countRelease("release");
    mcu_rstb = 1'b0;
    tick();
    checkOutput("mcu_rstb reasserts", {15'd0, cpu_rst_n}, 16'd0);
    mcu_rstb = 1'b1;
    tick();
    countRelease("restart");

    mcu_nmi_set = 1'b1;
    #1;
    checkOutput("nmi before edge sampled", {15'd0, nmi_n}, 16'd1);
    tick();
    checkOutput("nmi asserted", {15'd0, nmi_n}, 16'd0);
    mreq_n = 1'b0; A = 16'hD000; wr_n = 1'b0;
    tick();
    checkOutput("nmi acked", {15'd0, nmi_n}, 16'd1);
    mreq_n = 1'b1; wr_n = 1'b1; mcu_nmi_set = 1'b0;
    tick();
    mreq_n = 1'b0; wr_n = 1'b0; mcu_nmi_set = 1'b1;
    tick();
    checkOutput("nmi ack beats edge", {15'd0, nmi_n}, 16'd1);
    mreq_n = 1'b1; wr_n = 1'b1;
    tick();
    checkOutput("nmi no late set", {15'd0, nmi_n}, 16'd1);
    mcu_nmi_set = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);
    mreq_n = 1'b1; wr_n = 1'b1;
    tick();

    z80Write(10'h123, 8'h5A, 0);
    mainRead("sub write seen by main", 9'h123, 8'h5A);
    z80Write(10'h077, 8'hC3, 6);
    z80Read("held wr_n single write", 10'h077, 8'hC3);
    mainRead("held wr_n main view", 9'h077, 8'hC3);

    z80Write(10'h010, 8'h00, 0);
    mainWrite(9'h010, 8'h3C, 1'b1);
    z80Read("main write dropped", 10'h010, 8'h00);
    mainWrite(9'h010, 8'h3C, 1'b0);
    z80Read("main write granted", 10'h010, 8'h3C);

    mreq_n = 1'b0; A = 16'hC000; cpu_dout = 8'h55; wr_n = 1'b1;
    tick();
    wr_n = 1'b0;
    tick();
    main_AB = 9'h000; main_dout = 8'hAA; com_cs = 1'b1; main_wrn = 1'b0; busak_n = 1'b0;
    tick();
    com_cs = 1'b0; main_wrn = 1'b1; busak_n = 1'b1; wr_n = 1'b1; mreq_n = 1'b1;
    tick();
    mainRead("collision main view", 9'h000, 8'hAA);
    z80Read("collision sub view", 10'h000, 8'hAA);

    // Randomized traffic over a small address pool so reads hit earlier writes.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      pool[i] = 9'($urandom_range(0, 511));
      d = 8'($urandom);
      z80Write({1'b0, pool[i]}, d, 0);
      model[{1'b0, pool[i]}] = d;
    end
    for (int i = 0; i < 60; i++) begin
      logic [8:0] a;
      logic [7:0] d;
      logic       b;
      a = pool[$urandom_range(0, 7)];
      d = 8'($urandom);
      b = 1'($urandom);
      case ($urandom_range(0, 3))
        0: begin z80Write({1'b0, a}, d, $urandom_range(0, 2)); model[{1'b0, a}] = d; end
        1: begin mainWrite(a, d, b); if (!b) model[{1'b0, a}] = d; end
        2: mainRead("random main read", a, model[{1'b0, a}]);
        default: z80Read("random sub read", {1'b0, a}, model[{1'b0, a}]);
      endcase
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/jtdd2_sub_bus.md
# jtdd2_sub_bus

Bus glue for the Double Dragon 2 sub-CPU (Z80). It stretches the sub-CPU reset and latches the NMI request from the main CPU. It decodes the sub-CPU memory map and muxes read data. It also holds the 1 KB dual-port RAM shared with the main CPU. It sits between the external Z80/ROM-wait core and the main CPU bus; the Z80 core itself is outside this block.

## Interface
- Parameters: none (RAM size fixed at 1024×8).
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `mcu_rstb` in 1: synchronous active-low sub-CPU reset request from the main CPU.
- `cen4` in 1: sub-CPU clock enable.
- `main_AB` in 9: main CPU address into shared RAM.
- `main_wrn` in 1: main CPU write strobe, active low.
- `main_dout` in 8: main CPU write data.
- `com_cs` in 1: main CPU select of the shared RAM.
- `shared_dout` out 8: shared RAM read data toward the main CPU.
- `mcu_halt` in 1: main CPU requests the sub-CPU bus.
- `mcu_nmi_set` in 1: rising edge requests a sub-CPU NMI.
- `mcu_ban` out 1: equals the Z80 `busak_n`; low means the sub-CPU bus is granted.
- `mcu_irqmain` out 1: combinational; interrupt request to the main CPU.
- `cpu_rst_n` out 1: stretched reset to the Z80.
- `busrq_n` out 1: combinational, `~mcu_halt`.
- `nmi_n` out 1: NMI line to the Z80.
- `A` in 16: Z80 address.
- `mreq_n` in 1: Z80 memory request.
- `wr_n` in 1: Z80 write strobe.
- `busak_n` in 1: Z80 bus acknowledge.
- `cpu_dout` in 8: Z80 write data.
- `cpu_din` out 8: combinational Z80 read data.
- `rom_addr` out 16: equals `A`.
- `rom_cs` out 1: combinational ROM select, also routed to the ROM-wait logic.
- `rom_data` in 8: ROM read data.

## Operation
- Reset stretcher:
  - When `rst_n`=0 (asynchronous) or `mcu_rstb`=0 (synchronous): `cpu_rst_n`=0 and the 4-bit counter loads 15.
  - Otherwise, on each `cen4`: if the counter is non-zero it decrements; when it is 0, `cpu_rst_n` goes to 1.
  - Result: the Z80 is released on the 16th `cen4` after both resets are high.
  - `mcu_rstb` low mid-count or mid-run restarts the sequence.
- NMI latch:
  - A rising edge of `mcu_nmi_set` (registered previous sample compared with the current one) sets q.
  - `nmi_ack` clears q.
  - If clear and edge occur in the same cycle, clear wins.
  - q is held cleared while `cpu_rst_n`=0.
  - `nmi_n` = ~q.
- Decoder (all selects require `mreq_n`=0; otherwise every select is 0):
  - `A[15:14]`≠11 → `rom_cs`.
  - C000–C3FF → shared_cs.
  - C400–CFFF → no select.
  - Dxxx with `wr_n`=0 → `nmi_ack`.
  - Exxx with `wr_n`=0 → `mcu_irqmain`.
  - Fxxx → no select.
- `cpu_din` priority: `rom_data` if `rom_cs`, else shared port-A q if shared_cs, else 8'hFF.
- Shared RAM, 1024×8, true dual port, synchronous read on both ports:
  - Port A (sub-CPU): addr = `A[9:0]`, data = `cpu_dout`.
    - weA is a register: weA <= (`wr_n`=0) & (registered previous `wr_n`=1) & shared_cs.
    - This gives one write per falling edge of `wr_n`, committed the following cycle.
  - Port B (main CPU): addr = {0,`main_AB`}, data = `main_dout`.
    - weB = !`main_wrn` & `com_cs` & !`mcu_ban` (combinational).
    - Main writes therefore land only while the sub-CPU is halted; writes at other times are dropped.
  - Simultaneous writes to the same address: port B wins.
  - RAM contents are not reset.

## Timing
- Reset values: `cpu_rst_n`=0, `nmi_n`=1, weA=0, previous-`wr_n` register=1, `shared_dout`=0, port-A q=0.
- Read latency is 1 clk on both RAM ports; a write is visible on the next read.
- NMI: `nmi_n` falls 1 clk after the sampled rising edge of `mcu_nmi_set`, and rises 1 clk after `nmi_ack`.
- Port-A write occurs 1 clk after the `wr_n` falling edge; `A` and `cpu_dout` must still be valid then.

## Structure
- Memory-map constants (ROM limit, shared base/size, NMI-ack page, IRQ page) go in shared package `jtdd2_sub_pkg`.
- One natural sub-module, `jtdd2_sub_dpram`: a 1024×8 dual-port synchronous RAM with one-cycle read latency.
- Everything else is inline.

## Test plan
- Reset release: set `rst_n`=1 with `cen4` every 4th clk → `cpu_rst_n` rises after exactly 16 `cen4` pulses. Pulse `mcu_rstb` low → `cpu_rst_n`=0 immediately at the next clk, and the count restarts.
- NMI: rising edge on `mcu_nmi_set` → `nmi_n`=0. Z80 write to D000 → `nmi_n`=1. Edge plus ack in the same cycle → `nmi_n` stays 1.
- Decode: `mreq_n`=0 with `A`=8000 → `rom_cs`=1 and `cpu_din`=`rom_data`. `A`=C800 → `cpu_din`=FF. Write to E000 → `mcu_irqmain`=1. `mreq_n`=1 → all selects 0.
- Sub-CPU write: write 5A to C123 → main reads `main_AB`=123 → `shared_dout`=5A one clk later. Holding `wr_n` low across many clks → exactly one write.
- Main write gating: `com_cs`=1, `main_wrn`=0, data 3C, addr 010, `busak_n`=1 → no write. Repeat with `busak_n`=0 → Z80 reads C010 = 3C.
- Collision: both ports write 0x55 and 0xAA to address 0 in the same cycle (port A 0x55, port B 0xAA) → reads back 0xAA.
